// File: rtl/i2c_slave_regbank.sv
// rtl/i2c_slave_regbank.sv - I2C target with a byte-wide write/read register bank
// Optional SCL-stuck-low timeout is built when I2C_TIMEOUT_EN is defined.
module i2c_slave_regbank #(
    parameter int              DB_TOP  = 2,
    parameter int              N_WR    = 28,
    parameter int              N_RD    = 16,
    parameter int              RD_BASE = 8'h1C,
    parameter logic [8*N_WR-1:0] WR_INIT = '0,
    parameter logic [23:0]     TIMEOUT = 24'd1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          dev_adr,
    input  logic                scl_i,
    input  logic                sda_i,
    output logic                sda_o,
    output logic [8*N_WR-1:0]   wr_regs,
    output logic [N_WR-1:0]     wr_stb,
    input  logic [8*N_RD-1:0]   rd_regs,
    output logic [N_RD-1:0]     rd_stb,
    output logic                busy
);
    localparam int DBW = (DB_TOP < 1) ? 1 : $clog2(DB_TOP + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
        S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_WAIT
    } state_t;

    // bit 0 = SCL, bit 1 = SDA
    logic [1:0]     sync1_q, sync2_q, filt_q, filt_prev_q;
    logic [DBW-1:0] db_cnt_q [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            filt_prev_q <= 2'b11;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            sync1_q     <= {sda_i, scl_i};
            sync2_q     <= sync1_q;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DBW'(DB_TOP)) begin
                    filt_q[i]   <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_ev, stop_ev;
    assign scl_f    = filt_q[0];
    assign sda_f    = filt_q[1];
    assign scl_rise = scl_f & ~filt_prev_q[0];
    assign scl_fall = ~scl_f & filt_prev_q[0];
    assign start_ev = scl_f & filt_prev_q[0] & filt_prev_q[1] & ~sda_f;
    assign stop_ev  = scl_f & filt_prev_q[0] & ~filt_prev_q[1] & sda_f;

    state_t             state_q;
    logic [2:0]         bit_cnt_q;
    logic [6:0]         shift_q;
    logic [7:0]         ptr_q, tx_q;
    logic               rw_q, sda_o_q, busy_q;
    logic [8*N_WR-1:0]  wr_regs_q;
    logic [N_WR-1:0]    wr_stb_q;
    logic [N_RD-1:0]    rd_stb_q;
    logic               timeout_hit;

    logic [7:0]         byte_d, cap_ptr_d, cap_byte_d;
    logic [N_RD-1:0]    cap_stb_d;

    assign byte_d = {shift_q, sda_f};

    // A capture after a master ACK reads the register following the current ptr
    always_comb begin
        cap_ptr_d  = (state_q == S_RD_ACK) ? ptr_q + 8'd1 : ptr_q;
        cap_byte_d = 8'hFF;
        cap_stb_d  = '0;
        for (int k = 0; k < N_WR; k++) begin
            if (int'(cap_ptr_d) == k) cap_byte_d = wr_regs_q[8*k +: 8];
        end
        for (int j = 0; j < N_RD; j++) begin
            if (int'(cap_ptr_d) == RD_BASE + j) begin
                cap_byte_d   = rd_regs[8*j +: 8];
                cap_stb_d[j] = 1'b1;
            end
        end
    end

`ifdef I2C_TIMEOUT_EN
    logic [23:0] to_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || !busy_q || scl_f) to_cnt_q <= '0;
        else if (!timeout_hit)       to_cnt_q <= to_cnt_q + 24'd1;
    end

    assign timeout_hit = busy_q && !scl_f && (to_cnt_q == TIMEOUT - 24'd1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            tx_q      <= 8'hFF;
            rw_q      <= 1'b0;
            sda_o_q   <= 1'b1;
            busy_q    <= 1'b0;
            wr_regs_q <= WR_INIT;
            wr_stb_q  <= '0;
            rd_stb_q  <= '0;
        end else begin
            wr_stb_q <= '0;
            rd_stb_q <= '0;
            if (timeout_hit || stop_ev) begin
                state_q <= S_IDLE;
                sda_o_q <= 1'b1;
                busy_q  <= 1'b0;
            end else if (start_ev) begin
                state_q   <= S_ADDR;
                bit_cnt_q <= '0;
                sda_o_q   <= 1'b1;
            end else begin
                unique case (state_q)
                    S_IDLE, S_WAIT: sda_o_q <= 1'b1;
                    S_ADDR, S_REG, S_WR: begin
                        if (scl_fall) sda_o_q <= 1'b1;
                        if (scl_rise) begin
                            shift_q   <= byte_d[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (state_q == S_ADDR) begin
                                    if (byte_d[7:1] == dev_adr) begin
                                        state_q <= S_ADDR_ACK;
                                        rw_q    <= byte_d[0];
                                        busy_q  <= 1'b1;
                                    end else begin
                                        state_q <= S_WAIT;
                                        busy_q  <= 1'b0;
                                    end
                                end else if (state_q == S_REG) begin
                                    ptr_q   <= byte_d;
                                    state_q <= S_REG_ACK;
                                end else begin
                                    for (int k = 0; k < N_WR; k++) begin
                                        if (int'(ptr_q) == k) begin
                                            wr_regs_q[8*k +: 8] <= byte_d;
                                            wr_stb_q[k]         <= 1'b1;
                                        end
                                    end
                                    ptr_q   <= ptr_q + 8'd1;
                                    state_q <= S_WR_ACK;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK, S_REG_ACK, S_WR_ACK: begin
                        if (scl_fall) sda_o_q <= 1'b0;
                        if (scl_rise) begin
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                state_q  <= S_RD;
                                tx_q     <= cap_byte_d;
                                rd_stb_q <= cap_stb_d;
                            end else if (state_q == S_ADDR_ACK) begin
                                state_q <= S_REG;
                            end else begin
                                state_q <= S_WR;
                            end
                        end
                    end
                    S_RD: begin
                        if (scl_fall) begin
                            sda_o_q <= tx_q[7];
                            tx_q    <= {tx_q[6:0], 1'b1};
                        end
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) state_q <= S_RD_ACK;
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_fall) sda_o_q <= 1'b1;
                        if (scl_rise) begin
                            if (!sda_f) begin
                                ptr_q    <= cap_ptr_d;
                                tx_q     <= cap_byte_d;
                                rd_stb_q <= cap_stb_d;
                                state_q  <= S_RD;
                            end else begin
                                state_q <= S_WAIT;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign sda_o   = sda_o_q;
    assign busy    = busy_q;
    assign wr_regs = wr_regs_q;
    assign wr_stb  = wr_stb_q;
    assign rd_stb  = rd_stb_q;
endmodule

// File: tb/tb_i2c_slave_regbank.sv
// tb/tb_i2c_slave_regbank.sv - scoreboard bench driving an I2C master model against i2c_slave_regbank
module tb_i2c_slave_regbank;
    localparam int Q = 10;
    localparam logic [8*28-1:0] WR_INIT_TB = {{27{8'h00}}, 8'h3C};

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [6:0]     dev_adr = 7'h48;
    logic           scl_m = 1'b1;
    logic           sda_m = 1'b1;
    logic           sda_line;
    logic           sda_o;
    logic [223:0]   wr_regs;
    logic [27:0]    wr_stb;
    logic [127:0]   rd_regs = '0;
    logic [15:0]    rd_stb;
    logic           busy;

    int nchk = 0;
    int npass = 0;
    int exp_stb_q[$];
    int exp_bus_q[$];
    int obs_bus_q[$];

    always #5 clk = ~clk;
    assign sda_line = sda_m & sda_o;

    i2c_slave_regbank #(
        .DB_TOP(2), .N_WR(28), .N_RD(16), .RD_BASE(8'h1C),
        .WR_INIT(WR_INIT_TB), .TIMEOUT(24'd1000)
    ) dut (
        .clk(clk), .rst(rst), .dev_adr(dev_adr), .scl_i(scl_m), .sda_i(sda_line),
        .sda_o(sda_o), .wr_regs(wr_regs), .wr_stb(wr_stb), .rd_regs(rd_regs),
        .rd_stb(rd_stb), .busy(busy)
    );

    task automatic chk(string name, int act, int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // strobe codes: kind<<16 | index<<8 | value (kind 1 = write, 2 = read capture)
    task automatic stb_seen(int code);
        int e;
        e = (exp_stb_q.size() == 0) ? -1 : exp_stb_q.pop_front();
        chk("strobe", code, e);
    endtask

    task automatic bus_seen(int o);
        int e;
        e = (exp_bus_q.size() == 0) ? -1 : exp_bus_q.pop_front();
        chk("sda_bus", o, e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 28; k++)
                if (wr_stb[k]) stb_seen((1 << 16) | (k << 8) | int'(wr_regs[8*k +: 8]));
            for (int j = 0; j < 16; j++)
                if (rd_stb[j]) stb_seen((2 << 16) | (j << 8));
        end
    end

    always @(negedge clk) begin
        while (obs_bus_q.size() > 0) bus_seen(obs_bus_q.pop_front());
    end

    task automatic wclk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(logic b);
        sda_m = b; wclk(Q); scl_m = 1'b1; wclk(2*Q); scl_m = 1'b0; wclk(Q);
    endtask

    task automatic bit_in(output logic b);
        sda_m = 1'b1; wclk(Q); scl_m = 1'b1; wclk(Q); b = sda_line; wclk(Q); scl_m = 1'b0; wclk(Q);
    endtask

    task automatic start_c();
        sda_m = 1'b1; wclk(Q); scl_m = 1'b1; wclk(Q); sda_m = 1'b0; wclk(Q); scl_m = 1'b0; wclk(Q);
    endtask

    task automatic stop_c();
        sda_m = 1'b0; wclk(Q); scl_m = 1'b1; wclk(Q); sda_m = 1'b1; wclk(Q);
    endtask

    task automatic wr_byte(logic [7:0] d);
        logic a;
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(a);
        obs_bus_q.push_back(int'(a));
    endtask

    task automatic rd_byte(logic ack);
        logic [7:0] d;
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(ack);
        obs_bus_q.push_back(int'(d));
    endtask

    initial begin
        wclk(4);
        chk("rst_sda_o", int'(sda_o), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_stb", int'(wr_stb), 0);
        chk("rst_rd_stb", int'(rd_stb), 0);
        chk("rst_wr_regs", int'(wr_regs == WR_INIT_TB), 1);
        rst = 1'b0;
        wclk(20);

        // single write: dev 0x48, reg 0x03, data 0xA5
        exp_bus_q.push_back(0); exp_bus_q.push_back(0); exp_bus_q.push_back(0);
        exp_stb_q.push_back((1 << 16) | (3 << 8) | 8'hA5);
        start_c(); wr_byte(8'h90); wr_byte(8'h03); wr_byte(8'hA5); stop_c();
        wclk(10);
        chk("t1_reg3", int'(wr_regs[31:24]), 8'hA5);
        chk("t1_busy", int'(busy), 0);

        // burst write past the last writable register
        for (int i = 0; i < 5; i++) exp_bus_q.push_back(0);
        exp_stb_q.push_back((1 << 16) | (27 << 8) | 8'hFF);
        start_c(); wr_byte(8'h90); wr_byte(8'h1B);
        wr_byte(8'hFF); wr_byte(8'h00); wr_byte(8'h5A); stop_c();
        wclk(10);
        chk("t2_reg1b", int'(wr_regs[223:216]), 8'hFF);

        // write ptr then repeated START and read three status registers
        rd_regs[23:0] = 24'h332211;
        exp_bus_q.push_back(0); exp_bus_q.push_back(0); exp_bus_q.push_back(0);
        exp_bus_q.push_back(8'h11); exp_bus_q.push_back(8'h22); exp_bus_q.push_back(8'h33);
        exp_stb_q.push_back(2 << 16);
        exp_stb_q.push_back((2 << 16) | (1 << 8));
        exp_stb_q.push_back((2 << 16) | (2 << 8));
        start_c(); wr_byte(8'h90); wr_byte(8'h1C);
        start_c(); wr_byte(8'h91);
        rd_regs[7:0] = 8'h99;
        rd_byte(1'b0); rd_byte(1'b0); rd_byte(1'b1); stop_c();
        wclk(10);
        chk("t3_busy", int'(busy), 0);

        // foreign address: no ACK, no busy, following byte ignored
        exp_bus_q.push_back(1); exp_bus_q.push_back(1);
        start_c(); wr_byte(8'h92);
        chk("t4_busy", int'(busy), 0);
        chk("t4_sda_o", int'(sda_o), 1);
        wr_byte(8'h03); stop_c();
        wclk(10);
        chk("t4_reg3_kept", int'(wr_regs[31:24]), 8'hA5);

        // ptr = 0xFF, then read two bytes across the wrap
        exp_bus_q.push_back(0); exp_bus_q.push_back(0);
        start_c(); wr_byte(8'h90); wr_byte(8'hFF); stop_c();
        exp_bus_q.push_back(0); exp_bus_q.push_back(8'hFF); exp_bus_q.push_back(8'h3C);
        start_c(); wr_byte(8'h91); rd_byte(1'b0); rd_byte(1'b1); stop_c();
        wclk(10);

        // STOP after 5 data bits: partial byte dropped
        exp_bus_q.push_back(0); exp_bus_q.push_back(0);
        start_c(); wr_byte(8'h90); wr_byte(8'h05);
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1); bit_out(1'b0);
        stop_c();
        wclk(10);
        chk("t6_busy", int'(busy), 0);
        chk("t6_sda_o", int'(sda_o), 1);
        chk("t6_reg5", int'(wr_regs[47:40]), 0);

`ifdef I2C_TIMEOUT_EN
        // SCL stuck low mid-byte
        exp_bus_q.push_back(0); exp_bus_q.push_back(0);
        start_c(); wr_byte(8'h90); wr_byte(8'h06);
        bit_out(1'b1); bit_out(1'b1); bit_out(1'b0);
        wclk(880);
        chk("t7_busy_before", int'(busy), 1);
        wclk(200);
        chk("t7_busy_after", int'(busy), 0);
        chk("t7_sda_o", int'(sda_o), 1);
        stop_c();
        wclk(10);
        chk("t7_reg6", int'(wr_regs[55:48]), 0);
`endif

        wclk(20);
        chk("stb_q_left", exp_stb_q.size(), 0);
        chk("bus_q_left", exp_bus_q.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
